// File: rtl/rvc_asap_5pl_vga_capture.sv
// VGA loopback frame grabber: decodes sync timing, thresholds pixels to 1 bit, writes VGA-memory words.
// Latency: write registered 2 CLK_25 edges after the 8th pixel of a group is on the inputs; frame_done 2 edges after v_sync fall.
// Backpressure: none; the write port must accept one write every 8 cycles.
// Optional: define RVC_VGA_CAP_PIXCNT_EN to count lit pixels per captured frame into frame_pixels.
module rvc_asap_5pl_vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        CLK_25,
    input  logic        Reset,
    input  logic        cap_en,
    input  logic [3:0]  RED,
    input  logic [3:0]  GREEN,
    input  logic [3:0]  BLUE,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic [31:0] address,
    output logic [31:0] data,
    output logic [3:0]  byteena,
    output logic        wren,
    output logic        frame_done,
    output logic        sync_err,
    output logic [15:0] frame_cnt,
    output logic [18:0] frame_pixels
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  H_VIS1 = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0]  V_VIS0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_VIS1 = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    // Words per line: 8 one-bit pixels per byte lane word.
    localparam logic [31:0] WORDS_PER_LINE = 32'(H_ACTIVE / 8);

    typedef enum logic {SEEK, CAPTURE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        hs_q;
    logic        vs_q;
    logic        pix_q;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [7:0]  shreg;
    logic        done_q;
    logic        h_fall;
    logic        v_fall;
    logic        err_set;
    logic        done_set;
    logic        vis;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [31:0] word;

    // Edges are seen between the registered sync and the live input, so hcnt/vcnt line up with pix_q.
    assign h_fall = hs_q & ~h_sync;
    assign v_fall = vs_q & ~v_sync;

    // Next-state: arm at frame start, close the frame or abort on a bad line/frame period.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        done_set  = 1'b0;
        case (state)
            SEEK: begin
                if (v_fall && cap_en) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (v_fall) begin
                    // v check wins when both syncs fall together
                    if (vcnt != V_LAST) begin
                        err_set   = 1'b1;
                        state_nxt = SEEK;
                    end else begin
                        done_set  = 1'b1;
                        state_nxt = cap_en ? CAPTURE : SEEK;
                    end
                end else if (h_fall && hcnt != H_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = SEEK;
                end
            end
        endcase
    end

    // Pixel position decode for the registered sample.
    always_comb begin
        x    = hcnt - H_VIS0;
        y    = vcnt - V_VIS0;
        vis  = (state == CAPTURE) && (hcnt >= H_VIS0) && (hcnt <= H_VIS1) &&
               (vcnt >= V_VIS0) && (vcnt <= V_VIS1);
        word = 32'(y[9:2]) * WORDS_PER_LINE + 32'(x[9:3]);
    end

    // Input register stage, sync counters and FSM state.
    always_ff @(posedge CLK_25) begin
        if (Reset) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            pix_q <= 1'b0;
            hcnt  <= '0;
            vcnt  <= '0;
            state <= SEEK;
        end else begin
            hs_q  <= h_sync;
            vs_q  <= v_sync;
            pix_q <= |{RED, GREEN, BLUE};
            hcnt  <= h_fall ? 10'd0 : hcnt + 10'd1;
            if (v_fall) begin
                vcnt <= '0;
            end else if (h_fall) begin
                vcnt <= vcnt + 10'd1;
            end
            state <= state_nxt;
        end
    end

    // Collect 8 pixels and emit one byte-lane write on the last pixel of each group.
    always_ff @(posedge CLK_25) begin
        if (Reset) begin
            shreg   <= '0;
            address <= '0;
            data    <= '0;
            byteena <= '0;
            wren    <= 1'b0;
        end else begin
            wren <= 1'b0;
            if (vis) begin
                shreg[x[2:0]] <= pix_q;
                if (x[2:0] == 3'd7) begin
                    wren    <= 1'b1;
                    address <= word << 2;
                    data    <= {4{pix_q, shreg[6:0]}};
                    byteena <= 4'b0001 << y[1:0];
                end
            end
        end
    end

    // Frame-level status: done pulse one edge after the FSM closes a frame, sticky error.
    always_ff @(posedge CLK_25) begin
        if (Reset) begin
            done_q     <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            sync_err   <= 1'b0;
        end else begin
            done_q     <= done_set;
            frame_done <= done_q;
            if (done_q) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (err_set) begin
                sync_err <= 1'b1;
            end
        end
    end

`ifdef RVC_VGA_CAP_PIXCNT_EN
    logic [18:0] pixcnt;
    logic [18:0] pix_lat;

    // Lit-pixel counter: snapshot and clear at every frame start, publish with frame_done.
    always_ff @(posedge CLK_25) begin
        if (Reset) begin
            pixcnt       <= '0;
            pix_lat      <= '0;
            frame_pixels <= '0;
        end else begin
            if (v_fall) begin
                pix_lat <= pixcnt + 19'(vis & pix_q);
                pixcnt  <= '0;
            end else if (vis && pix_q) begin
                pixcnt <= pixcnt + 19'd1;
            end
            if (done_q) begin
                frame_pixels <= pix_lat;
            end
        end
    end
`else
    assign frame_pixels = '0;
`endif

endmodule
